// File: rtl/mem_stage_pkg.sv
// Shared types and default widths for the MEM-stage bus controller.
package mem_stage_pkg;

    localparam int DATA_W_DEFAULT = 32;
    localparam int REG_W_DEFAULT  = 5;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

endpackage

// File: rtl/mem_stage_ctrl.sv
// MEM pipeline stage: issues one bus access per load/store and stalls EX/MEM until ack.
// Optional feature: define MEM_ALIGN_CHECK_EN to trap word-misaligned accesses.
module mem_stage_ctrl
    import mem_stage_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT,
    parameter int REG_W  = REG_W_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] alu_result_in,
    input  logic [DATA_W-1:0] write_data_in,
    input  logic [REG_W-1:0]  write_register_in,
    input  logic              mem_read_in,
    input  logic              mem_write_in,
    input  logic              mem_to_reg_in,
    input  logic              reg_write_in,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] read_data_out,
    output logic [DATA_W-1:0] alu_result_out,
    output logic [REG_W-1:0]  write_register_out,
    output logic              mem_to_reg_out,
    output logic              reg_write_out,
    output logic              stall_out,
    output logic              misalign_out
);

    state_t              state_q, state_d;
    logic                mem_op, misaligned, accept, complete, stall;
    logic                we_q, mem_to_reg_q, reg_write_q;
    logic [REG_W-1:0]    wreg_q;

    assign mem_op = mem_read_in | mem_write_in;

`ifdef MEM_ALIGN_CHECK_EN
    assign misaligned = mem_op & (alu_result_in[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    assign accept = mem_op & ~misaligned;

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        state_d  = state_q;
        stall    = 1'b0;
        complete = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    stall   = 1'b1;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                stall = ~mem_ack;
                if (mem_ack) begin
                    complete = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Reset overrides everything so the stall line is quiet while reset is held.
        if (!reset) begin
            state_d  = IDLE;
            stall    = 1'b0;
            complete = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    assign mem_req   = (state_q == BUSY);
    assign mem_we    = (state_q == BUSY) & we_q;
    assign stall_out = stall;

    always_ff @(posedge clk) begin
        if (!reset) begin
            mem_addr           <= '0;
            mem_wdata          <= '0;
            we_q               <= 1'b0;
            wreg_q             <= '0;
            mem_to_reg_q       <= 1'b0;
            reg_write_q        <= 1'b0;
            read_data_out      <= '0;
            alu_result_out     <= '0;
            write_register_out <= '0;
            mem_to_reg_out     <= 1'b0;
            reg_write_out      <= 1'b0;
        end else begin
            if (state_q == IDLE && accept) begin
                mem_addr     <= alu_result_in;
                mem_wdata    <= write_data_in;
                we_q         <= mem_write_in & ~mem_read_in;  // read wins on conflict
                wreg_q       <= write_register_in;
                mem_to_reg_q <= mem_to_reg_in;
                reg_write_q  <= reg_write_in;
            end

            if (stall) begin
                reg_write_out  <= 1'b0;
                mem_to_reg_out <= 1'b0;
            end else if (complete) begin
                alu_result_out     <= mem_addr;
                write_register_out <= wreg_q;
                mem_to_reg_out     <= mem_to_reg_q;
                reg_write_out      <= reg_write_q;
                read_data_out      <= we_q ? '0 : mem_rdata;
            end else begin
                alu_result_out     <= alu_result_in;
                write_register_out <= write_register_in;
                mem_to_reg_out     <= mem_to_reg_in & ~misaligned;
                reg_write_out      <= reg_write_in & ~misaligned;
                read_data_out      <= '0;
            end
        end
    end

`ifdef MEM_ALIGN_CHECK_EN
    always_ff @(posedge clk) begin
        if (!reset) misalign_out <= 1'b0;
        else        misalign_out <= (state_q == IDLE) & misaligned;
    end
`else
    assign misalign_out = 1'b0;
`endif

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Self-checking bench for mem_stage_ctrl: directed scenarios plus randomized op stream.
module tb_mem_stage_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] alu_result_in, write_data_in, mem_rdata;
    logic [4:0]  write_register_in;
    logic        mem_read_in, mem_write_in, mem_to_reg_in, reg_write_in, mem_ack;
    logic        mem_req, mem_we, mem_to_reg_out, reg_write_out, stall_out, misalign_out;
    logic [31:0] mem_addr, mem_wdata, read_data_out, alu_result_out;
    logic [4:0]  write_register_out;
    logic [138:0] all_outs;

    int checks = 0;
    int errors = 0;

    mem_stage_ctrl dut (
        .clk                (clk),
        .reset              (reset),
        .alu_result_in      (alu_result_in),
        .write_data_in      (write_data_in),
        .write_register_in  (write_register_in),
        .mem_read_in        (mem_read_in),
        .mem_write_in       (mem_write_in),
        .mem_to_reg_in      (mem_to_reg_in),
        .reg_write_in       (reg_write_in),
        .mem_req            (mem_req),
        .mem_we             (mem_we),
        .mem_addr           (mem_addr),
        .mem_wdata          (mem_wdata),
        .mem_ack            (mem_ack),
        .mem_rdata          (mem_rdata),
        .read_data_out      (read_data_out),
        .alu_result_out     (alu_result_out),
        .write_register_out (write_register_out),
        .mem_to_reg_out     (mem_to_reg_out),
        .reg_write_out      (reg_write_out),
        .stall_out          (stall_out),
        .misalign_out       (misalign_out)
    );

    always #5 clk = ~clk;

    assign all_outs = {mem_req, mem_we, mem_addr, mem_wdata, read_data_out, alu_result_out,
                       write_register_out, mem_to_reg_out, reg_write_out, stall_out, misalign_out};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        alu_result_in     = '0;
        write_data_in     = '0;
        write_register_in = '0;
        mem_read_in       = 1'b0;
        mem_write_in      = 1'b0;
        mem_to_reg_in     = 1'b0;
        reg_write_in      = 1'b0;
        mem_ack           = 1'b0;
        mem_rdata         = '0;
    endtask

    // Reference behaviour of one EX/MEM op: a bus access holds the pipe for 1+delay
    // cycles then retires; anything else retires after one cycle.
    task automatic do_op(input logic rd, input logic wr, input logic m2r, input logic rw,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [4:0] wreg, input int delay,
                         input logic [31:0] rdata, input string tag);
        logic        is_mem, is_misal, is_access, exp_we;
        logic [31:0] exp_rd;
        int          stall_cycles;
        is_mem = rd | wr;
`ifdef MEM_ALIGN_CHECK_EN
        is_misal = is_mem && (addr[1:0] != 2'b00);
`else
        is_misal = 1'b0;
`endif
        is_access = is_mem && !is_misal;
        exp_we    = wr && !rd;
        exp_rd    = (is_access && !exp_we) ? rdata : 32'h0;

        mem_read_in       = rd;
        mem_write_in      = wr;
        mem_to_reg_in     = m2r;
        reg_write_in      = rw;
        alu_result_in     = addr;
        write_data_in     = wdata;
        write_register_in = wreg;
        stall_cycles      = 0;
        if (!is_access) begin
            mem_ack   = 1'($urandom_range(0, 1));
            mem_rdata = $urandom;
        end
        #1;
        checks++;
        if ({mem_req, stall_out} !== {1'b0, is_access}) begin
            errors++;
            $display("FAIL %s issue: req/stall got %b exp %b", tag, {mem_req, stall_out}, {1'b0, is_access});
        end
        if (stall_out === 1'b1) stall_cycles++;

        if (is_access) begin
            step();
            checks++;
            if ({reg_write_out, mem_to_reg_out} !== 2'b00) begin
                errors++;
                $display("FAIL %s bubble0: got %b exp 00", tag, {reg_write_out, mem_to_reg_out});
            end
            for (int k = 0; k <= delay; k++) begin
                mem_ack   = (k == delay);
                mem_rdata = (k == delay) ? rdata : $urandom;
                #1;
                checks++;
                if ({mem_req, mem_we, mem_addr, mem_wdata, stall_out} !==
                    {1'b1, exp_we, addr, wdata, (k != delay)}) begin
                    errors++;
                    $display("FAIL %s bus%0d: req/we/addr/wdata/stall got %b/%b/%h/%h/%b exp 1/%b/%h/%h/%b",
                             tag, k, mem_req, mem_we, mem_addr, mem_wdata, stall_out,
                             exp_we, addr, wdata, (k != delay));
                end
                if (stall_out === 1'b1) stall_cycles++;
                step();
                if (k < delay) begin
                    checks++;
                    if ({reg_write_out, mem_to_reg_out} !== 2'b00) begin
                        errors++;
                        $display("FAIL %s bubble%0d: got %b exp 00", tag, k + 1, {reg_write_out, mem_to_reg_out});
                    end
                end
            end
            mem_ack = 1'b0;
        end else begin
            step();
            mem_ack = 1'b0;
        end

        checks++;
        if (stall_cycles != (is_access ? delay + 1 : 0)) begin
            errors++;
            $display("FAIL %s stall_len: got %0d exp %0d", tag, stall_cycles, is_access ? delay + 1 : 0);
        end
        checks++;
        if ({alu_result_out, write_register_out, reg_write_out, mem_to_reg_out, read_data_out, misalign_out, mem_req} !==
            {addr, wreg, rw & !is_misal, m2r & !is_misal, exp_rd, is_misal, 1'b0}) begin
            errors++;
            $display("FAIL %s retire: alu/wreg/rw/m2r/rdata/mis/req got %h/%h/%b/%b/%h/%b/%b exp %h/%h/%b/%b/%h/%b/0",
                     tag, alu_result_out, write_register_out, reg_write_out, mem_to_reg_out,
                     read_data_out, misalign_out, mem_req, addr, wreg, rw & !is_misal,
                     m2r & !is_misal, exp_rd, is_misal);
        end
    endtask

    task automatic test_reset();
        checks++;
        if (all_outs !== '0) begin
            errors++;
            $display("FAIL reset_state: outputs got %h exp 0", all_outs);
        end
    endtask

    task automatic test_alu();
        do_op(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_1234, 32'h0, 5'd3, 0, 32'h0, "alu");
    endtask

    task automatic test_load();
        do_op(1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0100, 32'h0, 5'd9, 3, 32'hDEAD_BEEF, "load");
    endtask

    task automatic test_store();
        do_op(1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0020, 32'hA5A5_A5A5, 5'd0, 0, 32'h1357_9BDF, "store");
    endtask

    task automatic test_rd_wr_conflict();
        do_op(1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0040, 32'h5555_AAAA, 5'd12, 1, 32'h0BAD_F00D, "rdwr");
    endtask

    task automatic test_misalign();
        do_op(1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0102, 32'h0, 5'd4, 1, 32'h7777_8888, "misalign");
        do_op(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 0, 32'h0, "misalign_after");
    endtask

    task automatic test_reset_busy();
        mem_read_in       = 1'b1;
        mem_write_in      = 1'b0;
        mem_to_reg_in     = 1'b1;
        reg_write_in      = 1'b1;
        alu_result_in     = 32'h0000_0300;
        write_register_in = 5'd7;
        mem_ack           = 1'b0;
        step();
        step();
        checks++;
        if (mem_req !== 1'b1) begin
            errors++;
            $display("FAIL rst_busy_pre: mem_req got %b exp 1", mem_req);
        end
        reset = 1'b0;
        step();
        checks++;
        if (all_outs !== '0) begin
            errors++;
            $display("FAIL rst_busy_clear: outputs got %h exp 0", all_outs);
        end
        drive_idle();
        reset     = 1'b1;
        mem_ack   = 1'b1;
        mem_rdata = 32'hCAFE_F00D;
        step();
        checks++;
        if (all_outs !== '0) begin
            errors++;
            $display("FAIL rst_busy_late_ack: outputs got %h exp 0", all_outs);
        end
        mem_ack = 1'b0;
    endtask

    task automatic test_random();
        for (int n = 0; n < 60; n++) begin
            logic [31:0] addr;
            int          kind;
            kind = $urandom_range(0, 3);
            addr = $urandom;
            if ($urandom_range(0, 3) != 0) addr[1:0] = 2'b00;
            do_op(kind == 1 || kind == 3, kind == 2 || kind == 3, 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), addr, $urandom, 5'($urandom_range(0, 31)),
                  $urandom_range(0, 4), $urandom, "rand");
        end
    endtask

    initial begin
        reset = 1'b0;
        drive_idle();
        step();
        step();
        test_reset();
        reset = 1'b1;
        test_alu();
        test_load();
        test_store();
        test_rd_wr_conflict();
        test_misalign();
        test_reset_busy();
        test_random();
        test_load();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_stage_ctrl.md
MEM_STAGE_CTRL -- requirements
Module: mem_stage_ctrl

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- DATA_W, 32, data and address width.
- REG_W, 5, destination register index width.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low reset.
- alu_result_in  in  DATA_W  EX/MEM ALU result, used as the memory address.
- write_data_in  in  DATA_W  EX/MEM store data.
- write_register_in  in  REG_W  EX/MEM destination register.
- mem_read_in, mem_write_in, mem_to_reg_in, reg_write_in  in  1 each  EX/MEM control bits.
- mem_req  out  1  memory bus request.
- mem_we  out  1  bus write enable.
- mem_addr  out  DATA_W  bus address.
- mem_wdata  out  DATA_W  bus write data.
- mem_ack  in  1  bus completion.
- mem_rdata  in  DATA_W  bus read data, valid when mem_ack=1.
- read_data_out, alu_result_out  out  DATA_W  MEM/WB-bound data.
- write_register_out  out  REG_W  MEM/WB-bound destination register.
- mem_to_reg_out, reg_write_out  out  1  MEM/WB-bound control bits.
- stall_out  out  1  holds the upstream EX/MEM register.
- misalign_out  out  1  misaligned-access flag.

Function
REQ-003 The FSM SHALL have two states: IDLE and BUSY.
REQ-004 In IDLE, a memory op (mem_read_in|mem_write_in) SHALL latch address, data, we and destination info, set stall_out=1 combinationally, and enter BUSY at the next edge.
REQ-005 If mem_read_in and mem_write_in are both 1, the access SHALL be a read (mem_we=0).
REQ-006 In BUSY, the block SHALL hold mem_req=1 with mem_addr, mem_we and mem_wdata stable until mem_ack=1 is sampled.
REQ-007 In BUSY, stall_out SHALL equal !mem_ack.
REQ-008 On the edge where mem_ack=1 in BUSY:
- outputs SHALL register the latched op; read_data_out=mem_rdata for reads, 0 for writes;
- the FSM SHALL return to IDLE.
REQ-009 A non-memory op in IDLE SHALL pass through with 1-cycle latency and stall_out=0.
REQ-010 Minimum memory-op latency SHALL be 2 cycles (ack in the first BUSY cycle).
REQ-011 At every edge where stall_out=1, the block SHALL emit a bubble: reg_write_out=0, mem_to_reg_out=0.
REQ-012 mem_ack SHALL be ignored in IDLE.
REQ-013 mem_req SHALL be 0 in IDLE; there SHALL be no back-to-back request without an IDLE cycle.

Reset
REQ-014 At an edge with reset=0, the block SHALL enter IDLE and drive every output to 0, including mem_req, stall_out and misalign_out.
REQ-015 Reset during BUSY SHALL abandon the access, with mem_req=0 from the following cycle; a late mem_ack SHALL be ignored.

Configuration
REQ-016 With MEM_ALIGN_CHECK_EN defined, a memory op in IDLE with alu_result_in[1:0]!=0 SHALL:
- issue no bus request;
- not stall;
- pulse misalign_out=1 for one cycle, registered;
- force reg_write_out=0.
REQ-017 Without MEM_ALIGN_CHECK_EN, misalign_out SHALL be tied 0 and no address check SHALL exist.

Structure
REQ-018 Package mem_stage_pkg SHALL hold the IDLE/BUSY state type and the DATA_W/REG_W defaults.
REQ-019 The block SHALL be a single module; no sub-module is required.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- ALU op, reg_write_in=1, alu_result_in=0x1234 -> next cycle alu_result_out=0x1234, reg_write_out=1, stall_out=0.
- Load at 0x100, mem_ack after 3 BUSY cycles, mem_rdata=0xDEADBEEF -> stall_out=1 for 4 cycles; then read_data_out=0xDEADBEEF, reg_write_out=1.
- Store at 0x20, write_data_in=0xA5A5A5A5, immediate ack -> mem_we=1, mem_wdata=0xA5A5A5A5, one bus cycle, read_data_out=0.
- reset=0 in the second BUSY cycle of a load -> next cycle mem_req=0, all outputs 0; later mem_ack has no effect.
- With MEM_ALIGN_CHECK_EN, load at 0x102 -> mem_req stays 0, misalign_out=1 for one cycle, reg_write_out=0.
- mem_read_in=mem_write_in=1 at 0x40 -> mem_we=0 and the access completes as a read.
